// File: rtl/output_crossfade_limiter.sv
// Final mix stage: click-free linear crossfade between two signed streams,
// Q1.7 output gain and 16-bit saturation, 4-stage pipeline feeding the PDM.
module output_crossfade_limiter #(
    parameter int RAMP_LOG2 = 8
) (
    input  logic               audio_clk,
    input  logic               rst_in_n,
    input  logic               sample_valid_in,
    input  logic signed [15:0] audio_a_in,
    input  logic signed [15:0] audio_b_in,
    input  logic               select_in,
    input  logic [7:0]         gain_in,
    output logic signed [15:0] audio_out,
    output logic               audio_valid_out,
    output logic               busy_out,
    output logic               clip_out
);

    localparam int STAGES = 4;
    localparam int R      = 1 << RAMP_LOG2;
    localparam int WW     = RAMP_LOG2 + 1;      // w spans 0..R inclusive
    localparam int MW     = 16 + WW + 1;        // a*(R-w) + b*w without overflow
    localparam int GW     = 25;                 // 16b mix * 9b positive gain

    localparam logic [WW-1:0] W_MAX = WW'(R);
    localparam logic [WW-1:0] W_TOP = WW'(R - 1);
    localparam logic [WW-1:0] W_ONE = WW'(1);

    typedef enum logic [1:0] {
        HOLD_A,
        FADE_B,
        HOLD_B,
        FADE_A
    } state_t;

    state_t        state, state_nxt;
    logic [WW-1:0] w, w_nxt;

    always_ff @(posedge audio_clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state <= HOLD_A;
            w     <= '0;
        end else begin
            state <= state_nxt;
            w     <= w_nxt;
        end
    end

    // A reversal keeps the current w and steps the other way on the same strobe
    always_comb begin
        state_nxt = state;
        w_nxt     = w;
        if (sample_valid_in) begin
            case (state)
                HOLD_A: begin
                    if (select_in) begin
                        w_nxt     = w + W_ONE;
                        state_nxt = FADE_B;
                    end
                end
                FADE_B, FADE_A: begin
                    if (select_in) begin
                        w_nxt     = w + W_ONE;
                        state_nxt = (w == W_TOP) ? HOLD_B : FADE_B;
                    end else begin
                        w_nxt     = w - W_ONE;
                        state_nxt = (w == W_ONE) ? HOLD_A : FADE_A;
                    end
                end
                HOLD_B: begin
                    if (!select_in) begin
                        w_nxt     = w - W_ONE;
                        state_nxt = FADE_A;
                    end
                end
                default: begin
                    state_nxt = HOLD_A;
                    w_nxt     = '0;
                end
            endcase
        end
    end

    assign busy_out = (state == FADE_A) || (state == FADE_B);

    logic [STAGES:1] vld_pipe;

    always_ff @(posedge audio_clk or negedge rst_in_n) begin
        if (!rst_in_n) vld_pipe <= '0;
        else           vld_pipe <= {vld_pipe[STAGES-1:1], sample_valid_in};
    end

    assign audio_valid_out = vld_pipe[STAGES];

    // S1: capture the sample together with the pre-update weight
    logic signed [15:0] a_s1, b_s1;
    logic [WW-1:0]      w_s1;
    logic [7:0]         gain_s1;

    always_ff @(posedge audio_clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            a_s1    <= '0;
            b_s1    <= '0;
            w_s1    <= '0;
            gain_s1 <= '0;
        end else if (sample_valid_in) begin
            a_s1    <= audio_a_in;
            b_s1    <= audio_b_in;
            w_s1    <= w;
            gain_s1 <= gain_in;
        end
    end

    // S2: weighted sum, floor-shifted back to 16 bits (always in range)
    logic [WW-1:0]      inv_w;
    logic signed [MW-1:0] a_ext, b_ext, wa_ext, wb_ext, mix_sum;
    logic signed [15:0] mix_s2;
    logic [7:0]         gain_s2;

    always_comb begin
        inv_w   = W_MAX - w_s1;
        a_ext   = MW'(a_s1);
        b_ext   = MW'(b_s1);
        wa_ext  = MW'($signed({1'b0, inv_w}));
        wb_ext  = MW'($signed({1'b0, w_s1}));
        mix_sum = (a_ext * wa_ext) + (b_ext * wb_ext);
    end

    always_ff @(posedge audio_clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            mix_s2  <= '0;
            gain_s2 <= '0;
        end else if (vld_pipe[1]) begin
            mix_s2  <= 16'(mix_sum >>> RAMP_LOG2);
            gain_s2 <= gain_s1;
        end
    end

    // S3: Q1.7 gain; 18 bits hold the worst case of about +/-65280
    logic signed [GW-1:0] mix_ext, gain_ext, g_prod;
    logic signed [17:0]   g_s3;

    always_comb begin
        mix_ext  = GW'(mix_s2);
        gain_ext = GW'($signed({1'b0, gain_s2}));
        g_prod   = mix_ext * gain_ext;
    end

    always_ff @(posedge audio_clk or negedge rst_in_n) begin
        if (!rst_in_n)        g_s3 <= '0;
        else if (vld_pipe[2]) g_s3 <= 18'(g_prod >>> 7);
    end

    // S4: clamp to 16 bits and flag the clamp
    logic signed [15:0] sat_val;
    logic               sat_clip;

    always_comb begin
        sat_val  = 16'(g_s3);
        sat_clip = 1'b0;
        if (g_s3 > 18'sd32767) begin
            sat_val  = 16'sh7fff;
            sat_clip = 1'b1;
        end else if (g_s3 < -18'sd32768) begin
            sat_val  = -16'sh8000;
            sat_clip = 1'b1;
        end
    end

    always_ff @(posedge audio_clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            audio_out <= '0;
            clip_out  <= 1'b0;
        end else begin
            clip_out <= vld_pipe[3] & sat_clip;
            if (vld_pipe[3]) audio_out <= sat_val;
        end
    end

endmodule

// File: tb/tb_output_crossfade_limiter.sv
// Directed bench for output_crossfade_limiter: gain/saturation table, burst
// throughput, full and reversed crossfades, and asynchronous reset mid-fade.
module tb_output_crossfade_limiter;

    logic               audio_clk = 1'b0;
    logic               rst_in_n;
    logic               sample_valid_in;
    logic signed [15:0] audio_a_in, audio_b_in;
    logic               select_in;
    logic [7:0]         gain_in;
    logic signed [15:0] audio_out;
    logic               audio_valid_out, busy_out, clip_out;

    int checks = 0;
    int errors = 0;

    output_crossfade_limiter #(.RAMP_LOG2(8)) dut (
        .audio_clk       (audio_clk),
        .rst_in_n        (rst_in_n),
        .sample_valid_in (sample_valid_in),
        .audio_a_in      (audio_a_in),
        .audio_b_in      (audio_b_in),
        .select_in       (select_in),
        .gain_in         (gain_in),
        .audio_out       (audio_out),
        .audio_valid_out (audio_valid_out),
        .busy_out        (busy_out),
        .clip_out        (clip_out)
    );

    always #5 audio_clk = ~audio_clk;

    typedef struct {
        logic signed [15:0] a;
        logic signed [15:0] b;
        logic [7:0]         gain;
        int                 y;
        int                 clip;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 one cycle after the output hold check
    task automatic send(input string nm, input logic signed [15:0] a, input logic signed [15:0] b,
                        input logic sel, input logic [7:0] g,
                        output int y, output int c);
        int early;
        early = 0;
        audio_a_in = a; audio_b_in = b; select_in = sel; gain_in = g;
        sample_valid_in = 1'b1;
        @(posedge audio_clk); #1;
        sample_valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (audio_valid_out) early = 1;
            @(posedge audio_clk); #1;
        end
        chk({nm, "_latency"}, (early == 0 && audio_valid_out) ? 1 : 0, 1);
        y = audio_out;
        c = clip_out;
        @(posedge audio_clk); #1;
        chk({nm, "_hold"}, (!audio_valid_out && !clip_out && audio_out == y) ? 1 : 0, 1);
    endtask

    function automatic int fade_model(input int w);
        int t;
        t = 1000 * (256 - w) - 1000 * w;
        return t >>> 8;
    endfunction

    vec_t tbl[13];
    int   y, c, prev, anyv;
    logic signed [15:0] burst[4];

    initial begin
        rst_in_n = 1'b0;
        sample_valid_in = 1'b0;
        audio_a_in = '0; audio_b_in = '0; select_in = 1'b0; gain_in = '0;

        tbl[0]  = '{a: 16'sd1000,   b: -16'sd1000, gain: 8'd128, y: 1000,   clip: 0};
        tbl[1]  = '{a: 16'sd30000,  b: 16'sd0,     gain: 8'd255, y: 32767,  clip: 1};
        tbl[2]  = '{a: -16'sd30000, b: 16'sd0,     gain: 8'd255, y: -32768, clip: 1};
        tbl[3]  = '{a: 16'sd100,    b: 16'sd0,     gain: 8'd255, y: 199,    clip: 0};
        tbl[4]  = '{a: 16'sd1234,   b: -16'sd5,    gain: 8'd0,   y: 0,      clip: 0};
        tbl[5]  = '{a: -16'sd32768, b: 16'sd7,     gain: 8'd0,   y: 0,      clip: 0};
        tbl[6]  = '{a: -16'sd1,     b: 16'sd0,     gain: 8'd128, y: -1,     clip: 0};
        tbl[7]  = '{a: -16'sd1,     b: 16'sd0,     gain: 8'd1,   y: -1,     clip: 0};
        tbl[8]  = '{a: 16'sd32767,  b: 16'sd0,     gain: 8'd128, y: 32767,  clip: 0};
        tbl[9]  = '{a: 16'sd32767,  b: 16'sd0,     gain: 8'd129, y: 32767,  clip: 1};
        tbl[10] = '{a: -16'sd32768, b: 16'sd0,     gain: 8'd128, y: -32768, clip: 0};
        tbl[11] = '{a: 16'sd256,    b: 16'sd9999,  gain: 8'd64,  y: 128,    clip: 0};
        tbl[12] = '{a: -16'sd200,   b: 16'sd0,     gain: 8'd192, y: -300,   clip: 0};

        // reset state
        repeat (2) @(posedge audio_clk);
        #1;
        chk("rst_out",   audio_out, 0);
        chk("rst_flags", {audio_valid_out, busy_out, clip_out}, 0);
        rst_in_n = 1'b1;
        @(posedge audio_clk); #1;

        // gain / saturation table with A selected
        for (int i = 0; i < 13; i++) begin
            send($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, 1'b0, tbl[i].gain, y, c);
            chk($sformatf("vec%0d_out", i), y, tbl[i].y);
            chk($sformatf("vec%0d_clip", i), c, tbl[i].clip);
            chk($sformatf("vec%0d_busy", i), busy_out, 0);
        end

        // gain and select changes without a strobe are ignored
        gain_in = 8'd0; select_in = 1'b1;
        repeat (5) @(posedge audio_clk);
        #1;
        chk("nostrobe_out",  audio_out, -300);
        chk("nostrobe_busy", busy_out, 0);
        select_in = 1'b0;

        // back-to-back strobes, one output per cycle
        burst[0] = 16'sd10; burst[1] = -16'sd20; burst[2] = 16'sd30; burst[3] = 16'sd40;
        gain_in = 8'd128;
        for (int j = 0; j < 4; j++) begin
            audio_a_in = burst[j];
            sample_valid_in = 1'b1;
            @(posedge audio_clk); #1;
        end
        sample_valid_in = 1'b0;
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("burst%0d", j), (audio_valid_out && audio_out == burst[j]) ? 1 : 0, 1);
            @(posedge audio_clk); #1;
        end
        chk("burst_end", audio_valid_out, 0);

        // full fade A -> B: sample k uses w = k-1
        prev = 1000;
        for (int w = 0; w <= 256; w++) begin
            chk($sformatf("fade_busy_w%0d", w), busy_out, (w != 0 && w != 256) ? 1 : 0);
            send($sformatf("fade_w%0d", w), 16'sd1000, -16'sd1000, 1'b1, 8'd128, y, c);
            chk($sformatf("fade_out_w%0d", w), y, fade_model(w));
        end
        chk("fade_done_busy", busy_out, 0);

        // reverse at w = 100 from a fresh reset
        rst_in_n = 1'b0;
        @(posedge audio_clk); #1;
        rst_in_n = 1'b1;
        @(posedge audio_clk); #1;
        prev = 1000;
        for (int k = 0; k < 200; k++) begin
            int w;
            w = (k <= 100) ? k : 200 - k;
            chk($sformatf("rev_busy_%0d", k), busy_out, (w != 0) ? 1 : 0);
            send($sformatf("rev_%0d", k), 16'sd1000, -16'sd1000, (k < 100) ? 1'b1 : 1'b0, 8'd128, y, c);
            chk($sformatf("rev_out_%0d", k), y, fade_model(w));
            chk($sformatf("rev_step_%0d", k), ((y - prev) <= 8 && (prev - y) <= 8) ? 1 : 0, 1);
            prev = y;
        end
        chk("rev_end_busy", busy_out, 0);
        send("rev_hold_a", 16'sd1000, -16'sd1000, 1'b0, 8'd128, y, c);
        chk("rev_hold_a_out", y, 1000);

        // async reset at w = 50 with a sample in flight
        for (int w = 0; w < 50; w++) send("pre_rst", 16'sd1000, -16'sd1000, 1'b1, 8'd128, y, c);
        chk("pre_rst_out", y, fade_model(49));
        chk("pre_rst_busy", busy_out, 1);
        sample_valid_in = 1'b1;
        @(posedge audio_clk); #1;
        sample_valid_in = 1'b0;
        @(posedge audio_clk); #2;
        rst_in_n = 1'b0;
        #1;
        chk("async_rst_out", audio_out, 0);
        chk("async_rst_flags", {audio_valid_out, busy_out, clip_out}, 0);
        @(posedge audio_clk); #3;
        rst_in_n = 1'b1;
        anyv = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge audio_clk); #1;
            if (audio_valid_out) anyv = 1;
        end
        chk("flushed_pipe", anyv, 0);
        send("post_rst", 16'sd500, -16'sd1000, 1'b0, 8'd128, y, c);
        chk("post_rst_out", y, 500);
        chk("post_rst_clip", c, 0);
        chk("post_rst_busy", busy_out, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/output_crossfade_limiter.md
# output_crossfade_limiter

Final mixing stage between the processing chain and the `pdm` modulator. It takes two signed 16-bit audio streams, for example processed mic audio and the allpassed/convolved anti-noise signal. On a select change it crossfades between them linearly over a fixed number of samples, with no clicks. It then applies an output gain and saturates the result to 16 bits. Its output drives `pdm.level_in` directly.

## Interface
- `RAMP_LOG2`, default 8: crossfade length is 2^RAMP_LOG2 samples (256 by default).
- `audio_clk` in 1: 98.3 MHz audio clock.
- `rst_in_n` in 1: asynchronous, active-low reset.
- `sample_valid_in` in 1: one-cycle strobe per sample (24 kHz `audio_trigger`).
- `audio_a_in` in 16 signed: source A.
- `audio_b_in` in 16 signed: source B.
- `select_in` in 1: target source (0 = A, 1 = B). Sampled only on `sample_valid_in`.
- `gain_in` in 8 unsigned: output gain in Q1.7 format (128 = unity, 255 ≈ 1.99). Sampled with each sample.
- `audio_out` out 16 signed: mixed, gained, saturated sample. Held between valids.
- `audio_valid_out` out 1: one-cycle strobe when `audio_out` updates.
- `busy_out` out 1: high while a crossfade is in progress.
- `clip_out` out 1: one-cycle pulse coincident with `audio_valid_out` when saturation occurred.

## Operation
- Weight register `w`, unsigned, range 0..R where R = 2^RAMP_LOG2. `w` = 0 selects pure A; `w` = R selects pure B.
- FSM states, evaluated only on `sample_valid_in`:
  - HOLD_A (`w` = 0): if `select_in` = 1, go to FADE_B.
  - FADE_B: `w` += 1. When `w` reaches R, go to HOLD_B. If `select_in` = 0, go to FADE_A with no jump in `w`.
  - HOLD_B (`w` = R): if `select_in` = 0, go to FADE_A.
  - FADE_A: `w` -= 1. When `w` reaches 0, go to HOLD_A. If `select_in` = 1, go to FADE_B.
- Each sample is computed with the value of `w` before that strobe's update. The first faded sample after a select change uses `w` = 0 or R.
- `busy_out` = (state is FADE_A or FADE_B).
- Arithmetic:
  - mix = (a·(R−w) + b·w) >>> RAMP_LOG2. Full-precision signed sum (≥ 26 bits); arithmetic shift (floor). The result always fits in 16 bits.
  - g = (mix · {1'b0, gain_in}) >>> 7. Keep at least 25 bits before the shift.
  - Saturate g to [−32768, 32767]. Assert `clip_out` when clamped.
- Datapath is a 4-stage pipeline: S1 registers inputs and `w`; S2 forms the mix products and sum; S3 applies the gain product; S4 saturates and drives the output. It accepts a strobe every cycle.

## Timing
- Latency is 4 cycles: a strobe at edge N produces `audio_valid_out` at edge N+4, together with the new `audio_out` and `clip_out`.
- `audio_out` holds its value until the next `audio_valid_out`.
- Reset (asynchronous assert, independent of clock):
  - `audio_out` = 0, `audio_valid_out` = 0, `clip_out` = 0, `busy_out` = 0.
  - State = HOLD_A, `w` = 0, all pipeline valids cleared.
  - Reset asserted mid-fade or mid-pipeline discards in-flight samples.
- The first strobe after reset release is handled normally.
- A select toggle during a fade reverses direction at the current `w`. `w` never exceeds R and never goes below 0.
- `select_in` or `gain_in` changes without a strobe have no effect.

## Test plan
- Reset, then `select_in` = 0, a = 1000, b = −1000, gain = 128, strobe → `audio_out` = 1000 with `audio_valid_out` exactly 4 cycles later; `busy_out` = 0; `clip_out` = 0.
- Same inputs, `select_in` → 1, then 257 strobes → output 1000 on the first; 0 on the 129th (`w` = 128); −1000 on the 257th. `busy_out` is high from the first strobe through the 256th and low after.
- Reverse mid-fade: at `w` = 100 set `select_in` = 0 → `w` decrements to 0 over 100 strobes with no output discontinuity (step ≤ 8 LSB per sample); state ends in HOLD_A.
- Saturation: a = 30000, A selected, gain = 255 → `audio_out` = 32767 with `clip_out` pulse. a = −30000 → −32768 with pulse. a = 100, gain = 255 → 199 with no pulse.
- Gain = 0 with any inputs → `audio_out` = 0, no clip.
- Assert `rst_in_n` low at `w` = 50 with no clock edge → outputs 0 immediately; after release, first strobe with a = 500, select = 0 → 500 at +4 cycles and `busy_out` = 0.
